// File: rtl/escalonador_rr_pkg.sv
// Shared definitions for the round-robin process scheduler: FSM encodings,
// the OS pid and the default pid width.
package so_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SELECT = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_SAVE   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam int PID_SO     = 0;
  localparam int N_PROC_DEF = 4;
  localparam int PW         = $clog2(N_PROC_DEF);

endpackage

// File: rtl/escalonador_rr_fatia.sv
// Time-slice counter: counts enabled ticks and flags the tick that closes
// a quantum, wrapping back to zero on that same tick.
module contador_fatia #(
  parameter int QUANTUM = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic quantum_over
);

  localparam int             CW   = $clog2(QUANTUM);
  localparam logic [CW-1:0]  LAST = CW'(QUANTUM - 1);

  logic [CW-1:0] count;

  // Combinational so the pulse lands in the same cycle as the closing tick.
  assign quantum_over = en && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= quantum_over ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/escalonador_rr.sv
// Round-robin scheduler: picks the running user pid, sequences context
// restore/save strobes around each switch, and hands control back to the OS.
//
// state  | meaning
// IDLE   | OS owns the CPU, waiting for start
// SELECT | search the next active pid after ptr (or finish if none)
// LOAD   | restore incoming context, Set_ctx=1 ctx_dir=0
// RUN    | user pid executing, counting ticks
// SAVE   | save outgoing context, Set_ctx=1 ctx_dir=1
// DONE   | all launched pids halted, return to OS
module escalonador_rr
  import so_pkg::*;
#(
  parameter int N_PROC     = 4,
  parameter int QUANTUM    = 8,
  parameter int CTX_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N_PROC-2:0]         mask,
  input  logic                      tick,
  input  logic                      halt,
  input  logic                      preemp_mode,
  output logic [$clog2(N_PROC)-1:0] id_proc,
  output logic                      Set_ctx,
  output logic                      ctx_dir,
  output logic                      Set_pid_0,
  output logic                      quantum_over,
  output logic                      done
);

  localparam int              PIDW     = $clog2(N_PROC);
  localparam int              NU       = N_PROC - 1;
  localparam int              CCW      = $clog2(CTX_CYCLES + 1);
  localparam logic [CCW-1:0]  CTX_LAST = CCW'(CTX_CYCLES - 1);

  state_t          state;
  logic [NU-1:0]   ativos;
  logic [PIDW-1:0] ptr;
  logic [CCW-1:0]  ctx_cnt;
  logic            empty_start;
  logic            run;
  logic            tick_en;
  logic [PIDW-1:0] pid_sel;
  logic [NU-1:0]   retire_mask;

  // Bit i of act is pid i+1; the search begins just after p and wraps, so p
  // itself is the last candidate (lets a lone active pid be re-selected).
  function automatic logic [PIDW-1:0] next_pid(input logic [NU-1:0] act,
                                               input logic [PIDW-1:0] p);
    logic [PIDW-1:0] pick;
    logic [NU-1:0]   shifted;
    logic            hit;
    int              idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= NU; k++) begin
      idx     = (int'(p) + k - 1) % NU;
      shifted = act >> idx;
      if (!hit && shifted[0]) begin
        pick = PIDW'(idx + 1);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pid_sel = next_pid(ativos, ptr);
  assign run     = (state == ST_RUN);
  assign tick_en = tick & run;

  always_comb begin
    retire_mask = '0;
    for (int i = 0; i < NU; i++) begin
      retire_mask[i] = (id_proc == PIDW'(i + 1));
    end
  end

  contador_fatia #(.QUANTUM(QUANTUM)) u_fatia (
    .clk          (clk),
    .reset        (reset),
    .clear        (!run),
    .en           (tick_en),
    .quantum_over (quantum_over)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ativos      <= '0;
      ptr         <= '0;
      ctx_cnt     <= '0;
      id_proc     <= '0;
      empty_start <= 1'b0;
    end else begin
      empty_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mask != '0) begin
              ativos <= mask;
              ptr    <= '0;
              state  <= ST_SELECT;
            end else begin
              empty_start <= 1'b1;
            end
          end
        end
        ST_SELECT: begin
          if (ativos == '0) begin
            state <= ST_DONE;
          end else begin
            id_proc <= pid_sel;
            ctx_cnt <= CTX_LAST;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ctx_cnt == '0) state <= ST_RUN;
          else               ctx_cnt <= ctx_cnt - 1'b1;
        end
        ST_RUN: begin
          // A halting pid is dropped without saving its context.
          if (halt) begin
            ativos <= ativos & ~retire_mask;
            ptr    <= id_proc;
            state  <= ST_SELECT;
          end else if (quantum_over && preemp_mode) begin
            ctx_cnt <= CTX_LAST;
            state   <= ST_SAVE;
          end
        end
        ST_SAVE: begin
          if (ctx_cnt == '0) begin
            ptr   <= id_proc;
            state <= ST_SELECT;
          end else begin
            ctx_cnt <= ctx_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          id_proc <= PIDW'(PID_SO);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Set_ctx   = (state == ST_LOAD) || (state == ST_SAVE);
  assign ctx_dir   = (state == ST_SAVE);
  assign done      = (state == ST_DONE) || empty_start;
  assign Set_pid_0 = done;

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr (N_PROC=4, QUANTUM=8, CTX_CYCLES=2);
// inputs change and outputs are sampled on the falling edge.
module tb_escalonador_rr;
  import so_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset, start, tick, halt, preemp_mode;
  logic [N_PROC_DEF-2:0] mask;
  logic [PW-1:0]         id_proc;
  logic                  Set_ctx, ctx_dir, Set_pid_0, quantum_over, done;

  int n_cmp = 0;
  int n_bad = 0;

  escalonador_rr #(.N_PROC(4), .QUANTUM(8), .CTX_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mask         (mask),
    .tick         (tick),
    .halt         (halt),
    .preemp_mode  (preemp_mode),
    .id_proc      (id_proc),
    .Set_ctx      (Set_ctx),
    .ctx_dir      (ctx_dir),
    .Set_pid_0    (Set_pid_0),
    .quantum_over (quantum_over),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctx(input string tag, input int e_id, input int e_ctx, input int e_dir);
    chk({tag, ".id"},      32'(id_proc), 32'(e_id));
    chk({tag, ".set_ctx"}, 32'(Set_ctx), 32'(e_ctx));
    if (e_ctx != 0) chk({tag, ".ctx_dir"}, 32'(ctx_dir), 32'(e_dir));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; tick = 1'b0; halt = 1'b0;
    mask = '0; preemp_mode = 1'b0;
    cyc(1);
    reset = 1'b0;
  endtask

  // Returns at the falling edge of the first RUN cycle (start + 4).
  task automatic launch(input logic [2:0] m, input logic pm, input logic tk);
    mask = m; preemp_mode = pm; tick = tk; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
  endtask

  task automatic slice(input string tag, input int pid);
    for (int i = 0; i < 8; i++) begin
      chk_ctx(tag, pid, 0, 0);
      chk({tag, ".qo"}, 32'(quantum_over), (i == 7) ? 32'd1 : 32'd0);
      cyc(1);
    end
  endtask

  task automatic switch_ctx(input string tag, input int o, input int n);
    for (int i = 0; i < 2; i++) begin chk_ctx({tag, ".save"}, o, 1, 1); cyc(1); end
    chk_ctx({tag, ".select"}, o, 0, 0); cyc(1);
    for (int i = 0; i < 2; i++) begin chk_ctx({tag, ".load"}, n, 1, 0); cyc(1); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; halt = 1'b0;
    mask = '0; preemp_mode = 1'b0;
    cyc(1);
    chk("rst.id", 32'(id_proc), 0);
    chk("rst.set_ctx", 32'(Set_ctx), 0);
    chk("rst.ctx_dir", 32'(ctx_dir), 0);
    chk("rst.set_pid_0", 32'(Set_pid_0), 0);
    chk("rst.qo", 32'(quantum_over), 0);
    chk("rst.done", 32'(done), 0);
    reset = 1'b0;

    // 1: reset in the middle of RUN, then a normal relaunch
    launch(3'b010, 1'b0, 1'b0);
    chk_ctx("t1.run", 2, 0, 0);
    #2 reset = 1'b1;
    #1 chk_ctx("t1.async", 0, 0, 0);
    cyc(1);
    chk_ctx("t1.held", 0, 0, 0);
    chk("t1.done", 32'(done), 0);
    reset = 1'b0;
    mask = 3'b001; start = 1'b1;
    cyc(1); start = 1'b0;
    chk_ctx("t1.select", 0, 0, 0);
    cyc(1); chk_ctx("t1.load", 1, 1, 0);
    cyc(2); chk_ctx("t1.rerun", 1, 0, 0);

    // 2: three pids, preemptive, tick every cycle -> 1,2,3,1
    do_reset();
    launch(3'b111, 1'b1, 1'b1);
    slice("t2.s1", 1); switch_ctx("t2.w12", 1, 2);
    slice("t2.s2", 2); switch_ctx("t2.w23", 2, 3);
    slice("t2.s3", 3); switch_ctx("t2.w31", 3, 1);
    chk_ctx("t2.back1", 1, 0, 0);

    // 3: cooperative, pid1 halts after 20 ticks, pid3 after 5
    do_reset();
    launch(3'b101, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("t3.p1.id", 32'(id_proc), 1);
      chk("t3.p1.qo", 32'(quantum_over), (i == 7 || i == 15) ? 32'd1 : 32'd0);
      cyc(1);
    end
    tick = 1'b0; halt = 1'b1;
    cyc(1); chk_ctx("t3.nosave", 1, 0, 0);
    cyc(1); chk_ctx("t3.load3a", 3, 1, 0);
    cyc(1); chk_ctx("t3.load3b", 3, 1, 0);
    halt = 1'b0;
    cyc(1); chk_ctx("t3.run3", 3, 0, 0);
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3.p3.id", 32'(id_proc), 3);
      chk("t3.p3.qo", 32'(quantum_over), 0);
      cyc(1);
    end
    tick = 1'b0; halt = 1'b1;
    cyc(1); chk("t3.done_early", 32'(done), 0);
    halt = 1'b0;
    cyc(1);
    chk("t3.done", 32'(done), 1);
    chk("t3.set_pid_0", 32'(Set_pid_0), 1);
    cyc(1);
    chk("t3.done_off", 32'(done), 0);
    chk("t3.pid0_off", 32'(Set_pid_0), 0);
    chk_ctx("t3.os", 0, 0, 0);

    // 4: halt coincident with quantum_over
    do_reset();
    launch(3'b011, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t4.id", 32'(id_proc), 1);
      chk("t4.qo", 32'(quantum_over), (i == 7) ? 32'd1 : 32'd0);
      if (i == 7) begin
        halt = 1'b1;
        #1 chk("t4.qo_with_halt", 32'(quantum_over), 1);
      end
      cyc(1);
    end
    chk_ctx("t4.nosave", 1, 0, 0);
    halt = 1'b0;
    cyc(1); chk_ctx("t4.load2a", 2, 1, 0);
    cyc(1); chk_ctx("t4.load2b", 2, 1, 0);
    cyc(1); chk_ctx("t4.run2", 2, 0, 0);

    // 5: empty launch, then start ignored during RUN
    do_reset();
    mask = '0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t5.done", 32'(done), 1);
    chk("t5.set_pid_0", 32'(Set_pid_0), 1);
    chk_ctx("t5.idle", 0, 0, 0);
    cyc(1);
    chk("t5.done_off", 32'(done), 0);
    chk_ctx("t5.idle2", 0, 0, 0);
    launch(3'b010, 1'b0, 1'b0);
    mask = 3'b001; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_ctx("t5.ignore", 2, 0, 0);
    end
    start = 1'b0;

    // 6: single pid, preemptive -> saved and restored in place
    do_reset();
    launch(3'b010, 1'b1, 1'b1);
    slice("t6.s1", 2); switch_ctx("t6.w22", 2, 2);
    slice("t6.s2", 2);
    chk_ctx("t6.save_again", 2, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
